cpm5n_v1_0_1_fifo_head_mc: RTL and testbench
============================================

CPM5N_V1_0_1_FIFO_HEAD_MC -- requirements
Module: cpm5n_v1_0_1_fifo_head_mc

Interface
REQ-001 SHALL have parameter BUF_DATAWIDTH, default 256, entry width in bits.
REQ-002 SHALL have parameter NUM_CH, default 4, number of independent queues (1..16).
REQ-003 SHALL have parameter CH_DEPTH, default 24, entries per queue including head (2..1024, non-power-of-2 allowed).
REQ-004 SHALL have derived parameters CH_W = max(1,clog2(NUM_CH)) and CNT_W = clog2(CH_DEPTH+1), not overridden by users.
REQ-005 SHALL have ports: clkin input 1, sole clock; sync_reset input 1, synchronous active-high reset.
REQ-006 SHALL have ports: wr_en input 1, write strobe; wr_ch input CH_W, target queue; din input BUF_DATAWIDTH, write data.
REQ-007 SHALL have ports: rd_en input 1, dequeue strobe; rd_ch input CH_W, source queue; dout output BUF_DATAWIDTH, head of queue rd_ch.
REQ-008 SHALL have ports: ae_thresh input CNT_W and af_thresh input CNT_W, runtime thresholds shared by all queues.
REQ-009 SHALL have outputs empty, full, almost_empty, almost_full, each NUM_CH bits with one bit per queue.
REQ-010 SHALL have output count, NUM_CH*CNT_W bits, per-queue occupancy.
REQ-011 SHALL have outputs ovf_err and udf_err, each NUM_CH bits, sticky; plus input err_clr, 1 bit.

Function
REQ-012 SHALL accept one write and one read per cycle, on the same or different queues.
REQ-013 SHALL make dout first-word-fall-through: dout = head register of queue rd_ch, combinational mux, no read latency.
REQ-014 SHALL make a write to an empty queue visible at head with empty deasserted on the next clkin edge (1-cycle latency).
REQ-015 SHALL, on rd_en with count 1 and same-queue wr_en, load din into head; count stays 1; empty stays 0.
REQ-016 SHALL, on rd_en with count > 1, load the next stored entry into head on the same edge; count decrements.
REQ-017 SHALL drop a write to a queue with count == CH_DEPTH, leave state unchanged, and set ovf_err[wr_ch].
REQ-018 SHALL exempt same-queue simultaneous rd_en from REQ-017 so that the write is accepted.
REQ-019 SHALL ignore rd_en on an empty queue and set udf_err[rd_ch].
REQ-020 SHALL wrap per-queue write/read pointers from CH_DEPTH-2 to 0, with storage holding CH_DEPTH-1 entries behind the head.
REQ-021 SHALL register the flags from the next-state count: empty = (count==0); full = (count==CH_DEPTH); almost_empty = (count<=ae_thresh); almost_full = (count>=af_thresh).
REQ-022 SHALL apply threshold changes to the flags on the edge after the change.
REQ-023 SHALL clear all sticky error bits on err_clr; a new error in the same cycle wins.
REQ-024 SHALL treat out-of-range wr_ch/rd_ch (>= NUM_CH) as no-op without setting flags.

Reset
REQ-025 SHALL, with sync_reset high at clkin, zero all counts, pointers, heads and error bits.
REQ-026 SHALL set empty and almost_empty to all-ones and full and almost_full to zero on reset; dout reads 0.
REQ-027 SHALL give sync_reset priority over wr_en/rd_en in the same cycle, with in-flight writes discarded.
REQ-028 SHALL leave the storage array unreset; no path SHALL expose unwritten storage.

Structure
REQ-029 SHALL place the clog2 helper and a per-queue state struct (wptr, rptr, count) in cpm5n_v1_0_1_pkg.
REQ-030 SHALL use distributed RAM for storage: NUM_CH*(CH_DEPTH-1) entries, with addressing ch*(CH_DEPTH-1)+ptr.
REQ-031 SHALL place per-queue control (pointers, count, head-load select, flags) in sub-module cpm5n_v1_0_1_fifo_head_ctl, instantiated NUM_CH times.

Verification
REQ-032 SHALL cover: reset, then 3 writes to ch2 (0xA,0xB,0xC) -> next cycle empty[2]=0, dout(rd_ch=2)=0xA, count[2]=3; reads return A,B,C, then empty[2]=1.
REQ-033 SHALL cover: fill ch0 with 24 writes -> full[0]=1; 25th write -> dropped, ovf_err[0]=1; drain -> data 1..24 in order across pointer wrap.
REQ-034 SHALL cover: count[1]=1, same-cycle rd+wr ch1 din=0x55 -> count stays 1, dout=0x55 next cycle, empty[1] never asserts.
REQ-035 SHALL cover: simultaneous wr ch3 and rd ch0 every cycle for 100 cycles, random data -> scoreboard match, no cross-queue corruption.
REQ-036 SHALL cover: rd_en on empty ch1 -> udf_err[1]=1, count unchanged; err_clr -> 0; af_thresh 4->2 with count 3 -> almost_full=1 next edge.
REQ-037 SHALL cover: sync_reset asserted mid-burst with wr_en high -> all counts 0, empty all-ones the following cycle.

Source files
------------

// File: rtl/cpm5n_v1_0_1_pkg.sv
// Shared types and helpers for the multi-channel head-register FIFO.
// Queue state widths are sized for the largest supported depth of 1024 entries.
package cpm5n_v1_0_1_pkg;

  localparam int PTR_W  = 10;
  localparam int QCNT_W = 11;

  typedef struct packed {
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [QCNT_W-1:0] count;
  } q_state_t;

  typedef enum logic [1:0] {
    HEAD_HOLD,
    HEAD_LD_DIN,
    HEAD_LD_MEM
  } head_sel_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Storage ring holds depth-1 slots, so the last index is depth-2.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int depth);
    return (p == PTR_W'(depth - 2)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/cpm5n_v1_0_1_fifo_head_ctl.sv
// Per-queue control: pointers, occupancy, head-load select, registered flags, sticky errors.
// Flags follow the next-state count with one edge of latency; writes to a full queue are dropped.
module cpm5n_v1_0_1_fifo_head_ctl
  import cpm5n_v1_0_1_pkg::*;
#(
  parameter int CH_DEPTH = 24,
  parameter int CNT_W    = 5
) (
  input  logic             clk_i,
  input  logic             sync_reset_i,
  input  logic             wr_hit_i,
  input  logic             rd_hit_i,
  input  logic             err_clr_i,
  input  logic [CNT_W-1:0] ae_thresh_i,
  input  logic [CNT_W-1:0] af_thresh_i,
  output logic             mem_we_o,
  output logic             head_ld_din_o,
  output logic             head_ld_mem_o,
  output logic [PTR_W-1:0] wptr_o,
  output logic [PTR_W-1:0] rptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_empty_o,
  output logic             almost_full_o,
  output logic             ovf_err_o,
  output logic             udf_err_o
);

  localparam logic [QCNT_W-1:0] DEPTH_C = QCNT_W'(CH_DEPTH);
  localparam logic [QCNT_W-1:0] ONE_C   = QCNT_W'(1);

  q_state_t  st_q, st_d;
  head_sel_e head_sel;
  logic      is_empty, is_full, do_rd, do_wr, mem_we, ovf_now, udf_now;
  logic      empty_q, full_q, ae_q, af_q, ovf_q, udf_q;

  always_comb begin
    st_d     = st_q;
    head_sel = HEAD_HOLD;
    mem_we   = 1'b0;
    is_empty = (st_q.count == '0);
    is_full  = (st_q.count == DEPTH_C);
    do_rd    = rd_hit_i && !is_empty;
    // A same-cycle dequeue frees a slot, so a full queue still accepts the write.
    do_wr    = wr_hit_i && (!is_full || do_rd);
    ovf_now  = wr_hit_i && !do_wr;
    udf_now  = rd_hit_i && is_empty;

    if (do_rd) begin
      if (st_q.count == ONE_C) begin
        if (do_wr) head_sel = HEAD_LD_DIN;
        else       st_d.count = st_q.count - ONE_C;
      end else begin
        head_sel  = HEAD_LD_MEM;
        st_d.rptr = ptr_inc(st_q.rptr, CH_DEPTH);
        if (do_wr) begin
          mem_we    = 1'b1;
          st_d.wptr = ptr_inc(st_q.wptr, CH_DEPTH);
        end else begin
          st_d.count = st_q.count - ONE_C;
        end
      end
    end else if (do_wr) begin
      if (is_empty) begin
        head_sel = HEAD_LD_DIN;
      end else begin
        mem_we    = 1'b1;
        st_d.wptr = ptr_inc(st_q.wptr, CH_DEPTH);
      end
      st_d.count = st_q.count + ONE_C;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_reset_i) begin
      st_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      empty_q <= (st_d.count == '0);
      full_q  <= (st_d.count == DEPTH_C);
      ae_q    <= (st_d.count <= QCNT_W'(ae_thresh_i));
      af_q    <= (st_d.count >= QCNT_W'(af_thresh_i));
      ovf_q   <= ovf_now | (ovf_q & ~err_clr_i);
      udf_q   <= udf_now | (udf_q & ~err_clr_i);
    end
  end

  assign mem_we_o       = mem_we;
  assign head_ld_din_o  = (head_sel == HEAD_LD_DIN);
  assign head_ld_mem_o  = (head_sel == HEAD_LD_MEM);
  assign wptr_o         = st_q.wptr;
  assign rptr_o         = st_q.rptr;
  assign count_o        = st_q.count[CNT_W-1:0];
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_empty_o = ae_q;
  assign almost_full_o  = af_q;
  assign ovf_err_o      = ovf_q;
  assign udf_err_o      = udf_q;

endmodule

// File: rtl/cpm5n_v1_0_1_fifo_head_mc.sv
// Multi-channel FIFO with per-queue head registers; dout is first-word-fall-through (0-cycle read).
// One write and one read per cycle; writes to a full queue are dropped and flagged, no stall.
module cpm5n_v1_0_1_fifo_head_mc
  import cpm5n_v1_0_1_pkg::*;
#(
  parameter int BUF_DATAWIDTH = 256,
  parameter int NUM_CH        = 4,
  parameter int CH_DEPTH      = 24,
  localparam int CH_W         = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1,
  localparam int CNT_W        = clog2(CH_DEPTH + 1)
) (
  input  logic                      clkin,
  input  logic                      sync_reset,
  input  logic                      wr_en,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [BUF_DATAWIDTH-1:0]  din,
  input  logic                      rd_en,
  input  logic [CH_W-1:0]           rd_ch,
  output logic [BUF_DATAWIDTH-1:0]  dout,
  input  logic [CNT_W-1:0]          ae_thresh,
  input  logic [CNT_W-1:0]          af_thresh,
  output logic [NUM_CH-1:0]         empty,
  output logic [NUM_CH-1:0]         full,
  output logic [NUM_CH-1:0]         almost_empty,
  output logic [NUM_CH-1:0]         almost_full,
  output logic [NUM_CH*CNT_W-1:0]   count,
  output logic [NUM_CH-1:0]         ovf_err,
  output logic [NUM_CH-1:0]         udf_err,
  input  logic                      err_clr
);

  localparam int SLOTS = CH_DEPTH - 1;
  localparam int MEM_N = NUM_CH * SLOTS;
  localparam int AW    = (clog2(MEM_N) > 1) ? clog2(MEM_N) : 1;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic                     wr_in_rng, rd_in_rng;
  logic [CH_W-1:0]          wr_idx, rd_idx;
  logic [NUM_CH-1:0]        mem_we, ld_din, ld_mem;
  logic [PTR_W-1:0]         wptr_a [NUM_CH];
  logic [PTR_W-1:0]         rptr_a [NUM_CH];
  logic [AW-1:0]            wr_addr, rd_addr;
  logic [BUF_DATAWIDTH-1:0] mem_q  [MEM_N];
  logic [BUF_DATAWIDTH-1:0] head_q [NUM_CH];
  logic [BUF_DATAWIDTH-1:0] mem_rdat;

  assign wr_in_rng = ({1'b0, wr_ch} < NUM_CH_L);
  assign rd_in_rng = ({1'b0, rd_ch} < NUM_CH_L);
  assign wr_idx    = wr_in_rng ? wr_ch : '0;
  assign rd_idx    = rd_in_rng ? rd_ch : '0;

  // Each queue owns a contiguous block of SLOTS entries in the shared array.
  assign wr_addr  = AW'(int'(wr_idx) * SLOTS + int'(wptr_a[wr_idx]));
  assign rd_addr  = AW'(int'(rd_idx) * SLOTS + int'(rptr_a[rd_idx]));
  assign mem_rdat = mem_q[rd_addr];

  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr_hit, rd_hit;

    assign wr_hit = wr_en && wr_in_rng && (wr_ch == CH_W'(g));
    assign rd_hit = rd_en && rd_in_rng && (rd_ch == CH_W'(g));

    cpm5n_v1_0_1_fifo_head_ctl #(
      .CH_DEPTH (CH_DEPTH),
      .CNT_W    (CNT_W)
    ) u_ctl (
      .clk_i          (clkin),
      .sync_reset_i   (sync_reset),
      .wr_hit_i       (wr_hit),
      .rd_hit_i       (rd_hit),
      .err_clr_i      (err_clr),
      .ae_thresh_i    (ae_thresh),
      .af_thresh_i    (af_thresh),
      .mem_we_o       (mem_we[g]),
      .head_ld_din_o  (ld_din[g]),
      .head_ld_mem_o  (ld_mem[g]),
      .wptr_o         (wptr_a[g]),
      .rptr_o         (rptr_a[g]),
      .count_o        (count[g*CNT_W +: CNT_W]),
      .empty_o        (empty[g]),
      .full_o         (full[g]),
      .almost_empty_o (almost_empty[g]),
      .almost_full_o  (almost_full[g]),
      .ovf_err_o      (ovf_err[g]),
      .udf_err_o      (udf_err[g])
    );
  end

  // Storage is never reset; only slots behind a non-empty head are ever read.
  always_ff @(posedge clkin) begin
    if (!sync_reset && (|mem_we)) mem_q[wr_addr] <= din;
  end

  always_ff @(posedge clkin) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (sync_reset)     head_q[c] <= '0;
      else if (ld_din[c]) head_q[c] <= din;
      else if (ld_mem[c]) head_q[c] <= mem_rdat;
    end
  end

  assign dout = rd_in_rng ? head_q[rd_idx] : '0;

endmodule

// File: tb/tb_cpm5n_v1_0_1_fifo_head_mc.sv
// Directed bench for the multi-channel head FIFO, checked against a queue-level reference model.
module tb_cpm5n_v1_0_1_fifo_head_mc;

  localparam int W     = 256;
  localparam int NCH   = 4;
  localparam int DEPTH = 24;

  logic           clkin;
  logic           sync_reset;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [W-1:0]   din;
  logic           rd_en;
  logic [1:0]     rd_ch;
  logic [W-1:0]   dout;
  logic [4:0]     ae_thresh;
  logic [4:0]     af_thresh;
  logic [3:0]     empty, full, almost_empty, almost_full;
  logic [19:0]    count;
  logic [3:0]     ovf_err, udf_err;
  logic           err_clr;

  cpm5n_v1_0_1_fifo_head_mc dut (
    .clkin        (clkin),
    .sync_reset   (sync_reset),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .din          (din),
    .rd_en        (rd_en),
    .rd_ch        (rd_ch),
    .dout         (dout),
    .ae_thresh    (ae_thresh),
    .af_thresh    (af_thresh),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .ovf_err      (ovf_err),
    .udf_err      (udf_err),
    .err_clr      (err_clr)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Reference model: one plain queue per channel plus registered flag/error images.
  logic [W-1:0] mq [NCH][$];
  logic [3:0]   m_ae, m_af, m_ovf, m_udf;
  logic         chk_en;
  int           checks;
  int           failures;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic w, r, rok, wok;
    int   n;
    for (int c = 0; c < NCH; c++) begin
      if (sync_reset) begin
        mq[c].delete();
        m_ae[c]  = 1'b1;
        m_af[c]  = 1'b0;
        m_ovf[c] = 1'b0;
        m_udf[c] = 1'b0;
      end else begin
        w   = wr_en && (int'(wr_ch) == c);
        r   = rd_en && (int'(rd_ch) == c);
        n   = mq[c].size();
        rok = r && (n > 0);
        wok = w && ((n < DEPTH) || rok);
        m_ovf[c] = (w && !wok) ? 1'b1 : (err_clr ? 1'b0 : m_ovf[c]);
        m_udf[c] = (r && n == 0) ? 1'b1 : (err_clr ? 1'b0 : m_udf[c]);
        if (rok) void'(mq[c].pop_front());
        if (wok) mq[c].push_back(din);
        m_ae[c] = (mq[c].size() <= int'(ae_thresh));
        m_af[c] = (mq[c].size() >= int'(af_thresh));
      end
    end
  endtask

  task automatic step(input logic we, input logic [1:0] wc, input logic [W-1:0] d,
                      input logic re, input logic [1:0] rc, input logic clr, input logic rst);
    wr_en      = we;
    wr_ch      = wc;
    din        = d;
    rd_en      = re;
    rd_ch      = rc;
    err_clr    = clr;
    sync_reset = rst;
    @(posedge clkin);
    model_edge();
    #1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    err_clr    = 1'b0;
    sync_reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [W-1:0] d);
    step(1'b1, ch, d, 1'b0, rd_ch, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] ch);
    step(1'b0, wr_ch, '0, 1'b1, ch, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic clr);
    step(1'b0, wr_ch, '0, 1'b0, rd_ch, clr, 1'b0);
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [3:0]  e_emp, e_full;
  logic [19:0] e_cnt;

  always @(negedge clkin) begin
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        e_emp[c]          = (mq[c].size() == 0);
        e_full[c]         = (mq[c].size() == DEPTH);
        e_cnt[c*5 +: 5]   = 5'(mq[c].size());
      end
      check("empty", empty, e_emp);
      check("full", full, e_full);
      check("count", count, e_cnt);
      check("almost_empty", almost_empty, m_ae);
      check("almost_full", almost_full, m_af);
      check("ovf_err", ovf_err, m_ovf);
      check("udf_err", udf_err, m_udf);
      if (mq[rd_ch].size() != 0) check("dout", dout, mq[rd_ch][0]);
    end
  end

  initial begin
    checks     = 0;
    failures   = 0;
    chk_en     = 1'b0;
    sync_reset = 1'b1;
    wr_en      = 1'b0;
    wr_ch      = '0;
    din        = '0;
    rd_en      = 1'b0;
    rd_ch      = '0;
    err_clr    = 1'b0;
    ae_thresh  = 5'd2;
    af_thresh  = 5'd20;

    step(1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk_en = 1'b1;
    check("rst_empty", empty, 4'hF);
    check("rst_ae", almost_empty, 4'hF);
    check("rst_full", full, 4'h0);
    check("rst_af", almost_full, 4'h0);
    check("rst_count", count, 20'h0);
    check("rst_dout", dout, '0);
    check("rst_errs", {ovf_err, udf_err}, 8'h0);

    // Three writes to ch2, then FWFT reads.
    rd_ch = 2'd2;
    wr(2'd2, 'hA);
    check("fwft_dout", dout, 'hA);
    check("fwft_empty2", empty[2], 1'b0);
    wr(2'd2, 'hB);
    wr(2'd2, 'hC);
    check("cnt2_is3", count[14:10], 5'd3);
    check("rd_A", dout, 'hA);
    rd(2'd2);
    check("rd_B", dout, 'hB);
    rd(2'd2);
    check("rd_C", dout, 'hC);
    rd(2'd2);
    check("ch2_empty", empty[2], 1'b1);

    // Fill ch0, overflow, drain across pointer wrap.
    for (int i = 1; i <= DEPTH; i++) wr(2'd0, W'(i));
    check("full0", full[0], 1'b1);
    check("cnt0_24", count[4:0], 5'd24);
    wr(2'd0, W'(25));
    check("ovf0", ovf_err[0], 1'b1);
    check("cnt0_kept", count[4:0], 5'd24);
    rd_ch = 2'd0;
    for (int i = 1; i <= DEPTH; i++) begin
      check("drain0", dout, W'(i));
      rd(2'd0);
    end
    check("ch0_empty", empty[0], 1'b1);
    idle(1'b1);
    check("ovf_cleared", ovf_err, 4'h0);

    // Full queue with simultaneous read+write on the same channel.
    for (int i = 1; i <= DEPTH; i++) wr(2'd2, W'(32'h200 + i));
    step(1'b1, 2'd2, 'h2FF, 1'b1, 2'd2, 1'b0, 1'b0);
    check("full_rdwr_no_ovf", ovf_err, 4'h0);
    check("full_rdwr_cnt", count[14:10], 5'd24);
    check("full_rdwr_head", dout, 'h202);
    for (int i = 0; i < DEPTH; i++) rd(2'd2);
    check("ch2_drained", empty[2], 1'b1);

    // Count 1 with same-cycle read and write.
    rd_ch = 2'd1;
    wr(2'd1, 'h11);
    step(1'b1, 2'd1, 'h55, 1'b1, 2'd1, 1'b0, 1'b0);
    check("c1_cnt", count[9:5], 5'd1);
    check("c1_dout", dout, 'h55);
    check("c1_empty", empty[1], 1'b0);
    rd(2'd1);

    // Concurrent write ch3 / read ch0 with random data.
    for (int i = 0; i < 10; i++) wr(2'd0, W'(32'h300 + i));
    for (int i = 0; i < 100; i++) step(1'b1, 2'd3, rnd(), 1'b1, 2'd0, 1'b0, 1'b0);
    check("ovf3", ovf_err[3], 1'b1);
    check("udf0", udf_err[0], 1'b1);
    check("cnt3_24", count[19:15], 5'd24);
    rd_ch = 2'd3;
    for (int i = 0; i < DEPTH; i++) rd(2'd3);

    // Underflow, error clear, threshold change.
    idle(1'b1);
    check("errs_clr", {ovf_err, udf_err}, 8'h0);
    rd(2'd1);
    check("udf1", udf_err, 4'b0010);
    check("udf1_cnt", count[9:5], 5'd0);
    step(1'b0, wr_ch, '0, 1'b1, 2'd0, 1'b1, 1'b0);
    check("clr_vs_new", udf_err, 4'b0001);
    idle(1'b1);
    af_thresh = 5'd4;
    wr(2'd1, 'h1);
    wr(2'd1, 'h2);
    wr(2'd1, 'h3);
    check("af1_thr4", almost_full[1], 1'b0);
    check("ae1_thr2", almost_empty[1], 1'b0);
    af_thresh = 5'd2;
    idle(1'b0);
    check("af1_thr2", almost_full[1], 1'b1);
    ae_thresh = 5'd3;
    idle(1'b0);
    check("ae1_thr3", almost_empty[1], 1'b1);

    // Reset mid-burst with a write in flight.
    wr(2'd1, 'h4);
    wr(2'd1, 'h5);
    step(1'b1, 2'd1, 'hDEAD, 1'b0, 2'd1, 1'b0, 1'b1);
    check("mid_rst_count", count, 20'h0);
    check("mid_rst_empty", empty, 4'hF);
    check("mid_rst_dout", dout, '0);
    idle(1'b0);
    check("post_rst_empty", empty, 4'hF);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
